// File: rtl/reg_block_transfer_if.sv
// reg_block_transfer_if: command, register-file and memory signals of the block-transfer engine
interface reg_block_transfer_if;
    logic        start;
    logic        is_load;
    logic [8:0]  reg_list;
    logic [31:0] base_addr;
    logic        writeback;
    logic [3:0]  base_reg;
    logic [3:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    modport master (
        input  start, is_load, reg_list, base_addr, writeback, base_reg,
        input  rf_read_data, mem_ack, mem_rdata,
        output rf_read_addr, rf_write_en, rf_write_addr, rf_write_data,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );
    modport slave (
        output start, is_load, reg_list, base_addr, writeback, base_reg,
        output rf_read_data, mem_ack, mem_rdata,
        input  rf_read_addr, rf_write_en, rf_write_addr, rf_write_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/reg_block_transfer.sv
// reg_block_transfer: LDM/STM engine moving r0..r8 to/from consecutive memory words, optional base writeback
module reg_block_transfer #(
    parameter int ADDR_STEP = 4
) (
    input logic                  clk,
    input logic                  reset,
    reg_block_transfer_if.master bus
);
    typedef enum logic [2:0] {IDLE, SCAN, MEM, RFWR, WB, DONE} state_t;
    state_t      state, state_nxt;
    logic        ld, wb_en, mem_we_q, empty;
    logic [8:0]  list;
    logic [31:0] base, rdata_q, mem_addr_q, mem_wdata_q, next_addr;
    logic [3:0]  wb_reg, count, idx, low_idx;
    logic [15:0] list_ext;
    assign list_ext  = {7'd0, bus.reg_list};
    assign next_addr = base + 32'(ADDR_STEP) * 32'(count);
    assign empty     = list == 9'd0;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    always_comb begin
        low_idx = 4'd0;
        for (int i = 8; i >= 0; i--)
            if (list[i]) low_idx = 4'(i);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? SCAN : IDLE;
            SCAN:    state_nxt = !empty ? MEM : (wb_en && count != 4'd0) ? WB : DONE;
            MEM:     state_nxt = !bus.mem_ack ? MEM : ld ? RFWR : SCAN;
            RFWR:    state_nxt = SCAN;
            WB:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.busy          = state != IDLE;
        bus.done          = state == DONE;
        bus.mem_req       = state == MEM;
        bus.rf_read_addr  = state == SCAN ? low_idx : 4'd0;
        bus.rf_write_en   = state == RFWR || state == WB;
        bus.rf_write_addr = state == RFWR ? idx : state == WB ? wb_reg : 4'd0;
        bus.rf_write_data = state == RFWR ? rdata_q : state == WB ? next_addr : 32'd0;
    end
    // writeback suppression is resolved once at start: PC is read-only, a loaded base register wins
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ld          <= 1'b0;
            wb_en       <= 1'b0;
            list        <= 9'd0;
            base        <= 32'd0;
            wb_reg      <= 4'd0;
            count       <= 4'd0;
            idx         <= 4'd0;
            rdata_q     <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            if (state == IDLE && bus.start) begin
                ld     <= bus.is_load;
                list   <= bus.reg_list;
                base   <= bus.base_addr;
                wb_reg <= bus.base_reg;
                count  <= 4'd0;
                wb_en  <= bus.writeback && bus.base_reg != 4'd9 && !(bus.is_load && list_ext[bus.base_reg]);
            end
            if (state == SCAN && !empty) begin
                idx         <= low_idx;
                mem_addr_q  <= next_addr;
                mem_we_q    <= ~ld;
                mem_wdata_q <= ld ? 32'd0 : bus.rf_read_data;
            end
            if (state == MEM && bus.mem_ack) begin
                list  <= list & ~(9'd1 << idx);
                count <= count + 4'd1;
                if (ld) rdata_q <= bus.mem_rdata;
            end
        end
endmodule

// File: tb/tb_reg_block_transfer.sv
// tb_reg_block_transfer: randomized bench checking reg_block_transfer against a transaction-level model
module tb_reg_block_transfer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_block_transfer_if bus();
    reg_block_transfer #(.ADDR_STEP(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] regs [16];
    logic [31:0] pre_val [16];
    logic [31:0] rd_tab [16];
    int          pre_req = 0, pre_ack = 0;
    string       obs_q[$];
    int          ack_delay = 1;
    bit          noise = 1'b0;
    int          wait_cnt = 0, hold_viol = 0;
    bit          hold_act = 1'b0;
    logic [64:0] held;
    int          vectors = 0, errors = 0;

    assign bus.rf_read_data = regs[bus.rf_read_addr];

    // register file commits on the falling edge; memory answers with a programmable ack latency
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (pre_req != pre_ack) begin
            for (int i = 0; i < 16; i++) regs[i] = pre_val[i];
            pre_ack = pre_req;
        end
        if (bus.rf_write_en) begin
            regs[bus.rf_write_addr] = bus.rf_write_data;
            obs_q.push_back($sformatf("R%0d=%h", bus.rf_write_addr, bus.rf_write_data));
        end
        if (bus.done) obs_q.push_back("D");
        if (bus.mem_req) begin
            if (hold_act && held !== {bus.mem_we, bus.mem_addr, bus.mem_wdata}) hold_viol++;
            hold_act = 1'b1;
            held = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
            if (wait_cnt >= ack_delay) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rd_tab[bus.mem_addr[5:2]];
                obs_q.push_back(bus.mem_we ? $sformatf("S%h:%h", bus.mem_addr, bus.mem_wdata)
                                           : $sformatf("L%h:%h/%h", bus.mem_addr, bus.mem_rdata, bus.mem_wdata));
                wait_cnt = 0;
                hold_act = 1'b0;
            end else wait_cnt++;
        end else begin
            wait_cnt = 0;
            hold_act = 1'b0;
            bus.mem_ack = noise ? 1'($urandom) : 1'b0;
            bus.mem_rdata = $urandom;
        end
    end

    function automatic string since(int mark);
        string s = "";
        for (int k = mark; k < obs_q.size(); k++) s = {s, obs_q[k], " "};
        return s;
    endfunction

    function automatic string join_q(string q[$]);
        string s = "";
        foreach (q[k]) s = {s, q[k], " "};
        return s;
    endfunction

    function automatic logic [108:0] outs();
        return {bus.busy, bus.done, bus.rf_write_en, bus.mem_req, bus.mem_we, bus.mem_addr,
                bus.mem_wdata, bus.rf_read_addr, bus.rf_write_addr, bus.rf_write_data};
    endfunction

    // expected transaction list: ascending registers, word k at base+4k, optional base update
    function automatic void model(input bit ld, input logic [8:0] list, input logic [31:0] base,
                                  input bit wb, input logic [3:0] breg, output string q[$]);
        int n = 0;
        logic [31:0] a;
        q = {};
        for (int i = 0; i < 9; i++)
            if (list[i]) begin
                a = base + 32'(4 * n);
                if (ld) begin
                    q.push_back($sformatf("L%h:%h/%h", a, rd_tab[a[5:2]], 32'd0));
                    q.push_back($sformatf("R%0d=%h", i, rd_tab[a[5:2]]));
                end else q.push_back($sformatf("S%h:%h", a, regs[i]));
                n++;
            end
        if (wb && n > 0 && breg != 4'd9 && !(ld && ((({7'd0, list} >> breg) & 16'd1) != 16'd0)))
            q.push_back($sformatf("R%0d=%h", breg, base + 32'(4 * n)));
        q.push_back("D");
    endfunction

    task automatic preload();
        pre_req++;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_xfer(input bit ld, input logic [8:0] list, input logic [31:0] base, input bit wb,
                            input logic [3:0] breg, input bit hold, output int cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.is_load = ld;
        bus.reg_list = list;
        bus.base_addr = base;
        bus.writeback = wb;
        bus.base_reg = breg;
        cyc = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            #1;
            bus.start = hold;
            bus.is_load = 1'($urandom);
            bus.reg_list = 9'($urandom);
            bus.base_addr = $urandom;
            bus.writeback = 1'($urandom);
            bus.base_reg = 4'($urandom);
            if (bus.done) break;
            if (cyc >= 400) begin
                cyc = -1;
                break;
            end
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", outs());
        end
        for (int i = 0; i < 16; i++) begin
            pre_val[i] = $urandom;
            rd_tab[i] = $urandom;
        end
        preload();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.mem_req, bus.rf_write_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b, want 0000", {bus.busy, bus.done, bus.mem_req, bus.rf_write_en});
        end
    endtask

    task automatic test_stm();
        int cyc, mark;
        string got;
        pre_val[0] = 32'hA;
        pre_val[2] = 32'hB;
        preload();
        ack_delay = 1;
        mark = obs_q.size();
        run_xfer(1'b0, 9'b000000101, 32'h100, 1'b0, 4'd0, 1'b0, cyc);
        got = since(mark);
        vectors++;
        if (got != "S00000100:0000000a S00000104:0000000b D ") begin
            errors++;
            $display("FAIL stm_basic: got '%s', want 'S00000100:0000000a S00000104:0000000b D '", got);
        end
    endtask

    task automatic test_ldm_writeback();
        int cyc, mark;
        string got;
        rd_tab[0] = 32'h11;
        rd_tab[1] = 32'h22;
        mark = obs_q.size();
        run_xfer(1'b1, 9'b100000010, 32'h200, 1'b1, 4'd3, 1'b0, cyc);
        got = since(mark);
        vectors++;
        if (got != "L00000200:00000011/00000000 R1=00000011 L00000204:00000022/00000000 R8=00000022 R3=00000208 D ") begin
            errors++;
            $display("FAIL ldm_wb_log: got '%s', want 'L00000200:00000011/00000000 R1=00000011 L00000204:00000022/00000000 R8=00000022 R3=00000208 D '", got);
        end
        vectors++;
        if ({regs[1], regs[8], regs[3]} !== {32'h11, 32'h22, 32'h208}) begin
            errors++;
            $display("FAIL ldm_wb_regs: got %h %h %h, want 00000011 00000022 00000208", regs[1], regs[8], regs[3]);
        end
    endtask

    task automatic test_wb_suppress();
        int cyc, mark;
        string got, want;
        string exp_q[$];
        logic [31:0] v;
        v = $urandom;
        rd_tab[0] = v;
        mark = obs_q.size();
        run_xfer(1'b1, 9'b000001000, 32'h300, 1'b1, 4'd3, 1'b0, cyc);
        got = since(mark);
        want = $sformatf("L00000300:%h/00000000 R3=%h D ", v, v);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL wb_loaded_wins: got '%s', want '%s'", got, want);
        end
        model(1'b0, 9'b000010010, 32'h400, 1'b1, 4'd9, exp_q);
        want = join_q(exp_q);
        mark = obs_q.size();
        run_xfer(1'b0, 9'b000010010, 32'h400, 1'b1, 4'd9, 1'b0, cyc);
        got = since(mark);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL wb_pc_readonly: got '%s', want '%s'", got, want);
        end
    endtask

    task automatic test_empty_and_hold();
        int cyc, mark;
        string got, want;
        string exp_q[$];
        mark = obs_q.size();
        run_xfer(1'b0, 9'd0, $urandom, 1'b1, 4'd2, 1'b0, cyc);
        vectors++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL empty_latency: got %0d cycles, want 2", cyc);
        end
        got = since(mark);
        vectors++;
        if (got != "D ") begin
            errors++;
            $display("FAIL empty_log: got '%s', want 'D '", got);
        end
        model(1'b0, 9'b011000100, 32'h8000_0010, 1'b1, 4'd4, exp_q);
        want = join_q(exp_q);
        mark = obs_q.size();
        run_xfer(1'b0, 9'b011000100, 32'h8000_0010, 1'b1, 4'd4, 1'b1, cyc);
        got = since(mark);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL hold_start_log: got '%s', want '%s'", got, want);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_start_idle: busy %b, want 0", bus.busy);
        end
    endtask

    task automatic test_wrap_and_stall();
        int cyc, mark, hv;
        string got, want;
        ack_delay = 5;
        hv = hold_viol;
        want = $sformatf("Sfffffffc:%h S00000000:%h D ", regs[0], regs[1]);
        mark = obs_q.size();
        run_xfer(1'b0, 9'b000000011, 32'hFFFF_FFFC, 1'b0, 4'd0, 1'b0, cyc);
        got = since(mark);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL wrap_log: got '%s', want '%s'", got, want);
        end
        vectors++;
        if (hold_viol != hv) begin
            errors++;
            $display("FAIL stall_stable: %0d changes while waiting, want 0", hold_viol - hv);
        end
        ack_delay = 1;
    endtask

    task automatic test_reset_mid();
        int cyc, mark;
        string got, want;
        logic [31:0] v;
        pre_val[5] = 32'h55;
        preload();
        ack_delay = 20;
        mark = obs_q.size();
        @(negedge clk);
        bus.start = 1'b1;
        bus.is_load = 1'b1;
        bus.reg_list = 9'b000100000;
        bus.base_addr = 32'h500;
        bus.writeback = 1'b1;
        bus.base_reg = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 10 && !bus.mem_req; k++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h, want 0", outs());
        end
        repeat (3) @(negedge clk);
        got = since(mark);
        vectors++;
        if (regs[5] !== 32'h55 || got != "") begin
            errors++;
            $display("FAIL reset_abandon: r5 %h log '%s', want 00000055 and empty log", regs[5], got);
        end
        reset = 1'b0;
        ack_delay = 1;
        v = $urandom;
        rd_tab[0] = v;
        want = $sformatf("L00000500:%h/00000000 R5=%h R2=00000504 D ", v, v);
        mark = obs_q.size();
        run_xfer(1'b1, 9'b000100000, 32'h500, 1'b1, 4'd2, 1'b0, cyc);
        got = since(mark);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL reset_restart: got '%s', want '%s'", got, want);
        end
    endtask

    task automatic test_random();
        int cyc, mark;
        string got;
        string exp_q[$];
        bit ld, wb;
        logic [8:0] list;
        logic [31:0] base;
        logic [3:0] breg;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) begin
                pre_val[i] = $urandom;
                rd_tab[i] = $urandom;
            end
            preload();
            ld = 1'($urandom);
            list = (t % 6 == 0) ? 9'd0 : 9'($urandom);
            base = $urandom;
            wb = 1'($urandom);
            breg = 4'($urandom_range(0, 9));
            ack_delay = $urandom_range(0, 3);
            noise = 1'($urandom);
            model(ld, list, base, wb, breg, exp_q);
            mark = obs_q.size();
            run_xfer(ld, list, base, wb, breg, 1'($urandom), cyc);
            vectors++;
            if (obs_q.size() - mark != exp_q.size()) begin
                errors++;
                $display("FAIL rand_len[%0d]: got %0d events, want %0d", t, obs_q.size() - mark, exp_q.size());
            end
            foreach (exp_q[k]) begin
                got = (mark + k < obs_q.size()) ? obs_q[mark + k] : "<none>";
                vectors++;
                if (got != exp_q[k]) begin
                    errors++;
                    $display("FAIL rand_event[%0d.%0d]: got %s, want %s", t, k, got, exp_q[k]);
                end
            end
        end
        noise = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.is_load = 1'b0;
        bus.reg_list = 9'd0;
        bus.base_addr = 32'd0;
        bus.writeback = 1'b0;
        bus.base_reg = 4'd0;
        test_reset();
        test_stm();
        test_ldm_writeback();
        test_wb_suppress();
        test_empty_and_hold();
        test_wrap_and_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
